inst_encoder: RTL and testbench
===============================

Name: inst_encoder

Overview:
- Builds 32-bit instruction words from decoded fields: type, registers, funct3, and a signed immediate. It is the inverse of the immediate generator.
- Range-checks the immediate, packs it into the I, LW, SW or branch bit layout, and buffers the words in a small FIFO.
- Words stream out over a valid/ready handshake with an auto-incrementing instruction-memory address.
- Used by the testbench program loader and the self-modifying-code path to feed instruction memory.

Parameters:
- DEPTH, 4, output FIFO depth in entries; power of two, at least 2.
- BASE_ADDR, 32'h0000_0000, byte address paired with the first emitted word.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- clear_i  input  1  synchronous flush: empties FIFO, reloads address, clears error.
- req_valid_i  input  1  request present.
- req_ready_o  output  1  request accepted this cycle when high together with req_valid_i.
- type_i  input  2  0 = I-type (0010011), 1 = LW (0000011), 2 = SW (0100011), 3 = branch (1100011).
- rd_i  input  5  destination register; ignored for SW and branch.
- rs1_i  input  5  source register 1.
- rs2_i  input  5  source register 2; ignored for I-type and LW.
- funct3_i  input  3  placed in bits 14:12 unchanged.
- imm_i  input  32  signed immediate as a byte offset.
- inst_valid_o  output  1  FIFO head valid.
- inst_ready_i  input  1  consumer takes the head this cycle.
- inst_o  output  32  encoded instruction at the FIFO head.
- addr_o  output  32  byte address for inst_o.
- err_o  output  1  sticky: at least one request was rejected for its immediate.

Behaviour:
- Reset (rst_i low, asynchronous):
  - FIFO empty; inst_valid_o = 0; inst_o = 0.
  - addr_o = BASE_ADDR; err_o = 0.
  - req_ready_o = 1 after reset releases.
- Acceptance:
  - req_ready_o = (FIFO count < DEPTH) and not clear_i.
  - A request is accepted on a cycle with req_valid_i & req_ready_o.
- Range check, evaluated on the accepted request:
  - I-type, LW, SW: imm_i must lie in -2048..2047.
  - Branch: imm_i must lie in -4096..4094 and imm_i[0] must be 0.
  - On failure the request is consumed, nothing is pushed, and err_o is set on the next edge. It stays set until clear_i or reset.
- Encoding, with imm meaning imm_i:
  - I-type and LW: {imm[11:0], rs1, funct3, rd, opcode}.
  - SW: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - Branch: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
- Latency:
  - A request accepted in cycle N is visible on inst_o with inst_valid_o = 1 in cycle N+1, provided nothing is queued ahead of it.
  - inst_o and addr_o come from registered FIFO state; neither has a combinational path from the request inputs.
- Pop:
  - Occurs on inst_valid_o & inst_ready_i.
  - Advances the FIFO head and adds 4 to addr_o (32-bit wrap, no flag).
  - inst_o and addr_o hold steady while inst_valid_o = 1 and inst_ready_i = 0.
- Push and pop in the same cycle: count unchanged; order preserved.
- Full (count = DEPTH): req_ready_o = 0. A pop in the same cycle does not make the block ready that cycle; ready returns the following cycle.
- Empty: inst_valid_o = 0. inst_ready_i is ignored.
- Pointers are log2(DEPTH) bits and wrap naturally. The count register is log2(DEPTH)+1 bits.
- clear_i has priority over push and pop in the same cycle:
  - the cycle's request is not accepted;
  - the FIFO is empty next cycle;
  - addr_o = BASE_ADDR and err_o = 0.
- Reset asserted mid-stream discards all queued words immediately.

Optional Feature:
- Macro: ENC_ROUNDTRIP_CHK_EN.
- Defined:
  - Adds output chk_fail_o (1 bit, sticky, reset 0, cleared by clear_i).
  - Every pushed word is decoded back using the immediate-generator rule:
    - I-type, LW: bits 31:20.
    - SW: {31:25, 11:7}.
    - Branch: {31, 7, 30:25, 11:8}.
    - The result is sign-extended from 12 bits.
  - It is compared with the expected value: imm_i for I-type, LW and SW; imm_i[12:1] sign-extended for branch.
  - A mismatch sets chk_fail_o on the next edge.
- Undefined: the port and logic are absent; behaviour is otherwise identical.

Test Plan:
- After reset: addr_o = 0, inst_valid_o = 0, err_o = 0. Send I-type rd=1, rs1=0, f3=0, imm=5 -> inst_o = 32'h00500093 one cycle later, addr_o = 0. Pop -> addr_o = 4.
- LW rd=2, rs1=1, f3=2, imm=8 -> 32'h0080A103. Then SW rs1=1, rs2=2, f3=2, imm=12 -> 32'h0020A623, in that order.
- Branch rs1=1, rs2=2, f3=0, imm=-8 -> 32'hFEE08CE3 is wrong; required 32'hFE208CE3. Check bit 7 = imm[11] = 1.
- I-type with imm=2048, then branch with imm=3 -> both consumed, no push, err_o = 1 from the cycle after the first. Next valid request is still encoded normally.
- Hold inst_ready_i = 0 and push DEPTH words -> req_ready_o = 0 with the 5th request pending. Raise inst_ready_i for 1 cycle -> the pending request is accepted the following cycle. All words emerge in order with addresses 0, 4, 8, ...
- With 3 words queued and err_o = 1, assert clear_i while req_valid_i = 1 -> that request is not accepted; next cycle inst_valid_o = 0, addr_o = BASE_ADDR, err_o = 0.

Source files
------------

// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - instruction word encoder with range check, output FIFO and address counter (option: ENC_ROUNDTRIP_CHK_EN)
module inst_encoder #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  type_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] imm_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] addr_o,
`ifdef ENC_ROUNDTRIP_CHK_EN
    output logic        chk_fail_o,
`endif
    output logic        err_o
);

    localparam int          AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] L_FULL = (AW + 1)'(DEPTH);

    logic [31:0]       r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic [31:0]       r_addr;
    logic              r_err;

    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_imm_ok;
    logic [6:0]        w_opcode;
    logic [31:0]       w_word;
    logic signed [31:0] w_imm_s;

    assign w_imm_s      = imm_i;
    assign req_ready_o  = (r_count < L_FULL) && !clear_i;
    assign w_accept     = req_valid_i && req_ready_o;
    assign w_push       = w_accept && w_imm_ok;
    assign inst_valid_o = (r_count != '0);
    assign w_pop        = inst_valid_o && inst_ready_i && !clear_i;
    assign inst_o       = inst_valid_o ? r_mem[r_rd_ptr] : 32'h0;
    assign addr_o       = r_addr;
    assign err_o        = r_err;

    // Range-check the immediate and pack the fields into the layout for the request type
    always_comb begin
        w_opcode = 7'b0010011;
        w_word   = 32'h0;
        w_imm_ok = 1'b0;
        case (type_i)
            2'd0: begin
                w_opcode = 7'b0010011;
                w_imm_ok = (w_imm_s >= -32'sd2048) && (w_imm_s <= 32'sd2047);
                w_word   = {imm_i[11:0], rs1_i, funct3_i, rd_i, w_opcode};
            end
            2'd1: begin
                w_opcode = 7'b0000011;
                w_imm_ok = (w_imm_s >= -32'sd2048) && (w_imm_s <= 32'sd2047);
                w_word   = {imm_i[11:0], rs1_i, funct3_i, rd_i, w_opcode};
            end
            2'd2: begin
                w_opcode = 7'b0100011;
                w_imm_ok = (w_imm_s >= -32'sd2048) && (w_imm_s <= 32'sd2047);
                w_word   = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], w_opcode};
            end
            default: begin
                w_opcode = 7'b1100011;
                w_imm_ok = (w_imm_s >= -32'sd4096) && (w_imm_s <= 32'sd4094) && !imm_i[0];
                w_word   = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                            imm_i[4:1], imm_i[11], w_opcode};
            end
        endcase
    end

    // FIFO storage; entries beyond the count are never observed so no reset is needed
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    // Pointers, occupancy, address counter and sticky range error
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_addr   <= BASE_ADDR;
            r_err    <= 1'b0;
        end else if (clear_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_addr   <= BASE_ADDR;
            r_err    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
                r_addr   <= r_addr + 32'd4;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_accept && !w_imm_ok) begin
                r_err <= 1'b1;
            end
        end
    end

`ifdef ENC_ROUNDTRIP_CHK_EN
    logic [31:0] w_dec_imm;
    logic [31:0] w_exp_imm;
    logic        r_chk_fail;

    assign chk_fail_o = r_chk_fail;

    // Decode the packed word back the way the immediate generator would
    always_comb begin
        w_dec_imm = 32'h0;
        w_exp_imm = imm_i;
        case (type_i)
            2'd0, 2'd1: w_dec_imm = {{20{w_word[31]}}, w_word[31:20]};
            2'd2:       w_dec_imm = {{20{w_word[31]}}, w_word[31:25], w_word[11:7]};
            default: begin
                w_dec_imm = {{20{w_word[31]}}, w_word[31], w_word[7], w_word[30:25], w_word[11:8]};
                w_exp_imm = {{20{imm_i[12]}}, imm_i[12:1]};
            end
        endcase
    end

    // Sticky flag for any pushed word whose immediate does not survive the round trip
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_chk_fail <= 1'b0;
        end else if (clear_i) begin
            r_chk_fail <= 1'b0;
        end else if (w_push && (w_dec_imm != w_exp_imm)) begin
            r_chk_fail <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_inst_encoder.sv
// tb/tb_inst_encoder.sv - self-checking bench for inst_encoder
module tb_inst_encoder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  type_s;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] imm;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] addr;
    logic        err;
`ifdef ENC_ROUNDTRIP_CHK_EN
    logic        chk_fail;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    inst_encoder #(.DEPTH(DEPTH), .BASE_ADDR(32'h0)) dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .clear_i      (clear),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .type_i       (type_s),
        .rd_i         (rd),
        .rs1_i        (rs1),
        .rs2_i        (rs2),
        .funct3_i     (f3),
        .imm_i        (imm),
        .inst_valid_o (inst_valid),
        .inst_ready_i (inst_ready),
        .inst_o       (inst),
        .addr_o       (addr),
`ifdef ENC_ROUNDTRIP_CHK_EN
        .chk_fail_o   (chk_fail),
`endif
        .err_o        (err)
    );

    typedef struct {
        int          t;
        int          rd;
        int          rs1;
        int          rs2;
        int          f3;
        int          imm;
        logic [31:0] exp_word;
        logic        exp_err;
    } vec_t;

    vec_t vecs [13];

    function automatic vec_t mk(int t, int r_d, int r_s1, int r_s2, int fn3, int im,
                                logic [31:0] w, logic e);
        vec_t v;
        v.t = t; v.rd = r_d; v.rs1 = r_s1; v.rs2 = r_s2; v.f3 = fn3; v.imm = im;
        v.exp_word = w; v.exp_err = e;
        return v;
    endfunction

    // Reference encoder written as shifts and masks of the raw immediate value
    function automatic logic [31:0] model_enc(int t, int r_d, int r_s1, int r_s2, int fn3, int im);
        int unsigned u;
        int unsigned ops [4];
        int unsigned w;
        ops[0] = 'h13; ops[1] = 'h03; ops[2] = 'h23; ops[3] = 'h63;
        u = im;
        w = ops[t] | (unsigned'(fn3) << 12) | (unsigned'(r_s1) << 15);
        if (t < 2)
            w = w | ((u & 'hFFF) << 20) | (unsigned'(r_d) << 7);
        else if (t == 2)
            w = w | (((u >> 5) & 'h7F) << 25) | (unsigned'(r_s2) << 20) | ((u & 'h1F) << 7);
        else
            w = w | (((u >> 12) & 1) << 31) | (((u >> 5) & 'h3F) << 25) | (unsigned'(r_s2) << 20)
                  | (((u >> 1) & 'hF) << 8) | (((u >> 11) & 1) << 7);
        return w;
    endfunction

    function automatic bit model_ok(int t, int im);
        if (t < 3) return (im >= -2048) && (im <= 2047);
        return (im >= -4096) && (im <= 4094) && ((im & 1) == 0);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_req(input int t, input int r_d, input int r_s1, input int r_s2,
                           input int fn3, input int im);
        req_valid = 1'b1;
        type_s    = t[1:0];
        rd        = r_d[4:0];
        rs1       = r_s1[4:0];
        rs2       = r_s2[4:0];
        f3        = fn3[2:0];
        imm       = im;
    endtask

    // Advance one clock; inputs are changed and outputs sampled 2 units after the edge
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_clear();
        clear = 1'b1; req_valid = 1'b0; inst_ready = 1'b0;
        step();
        clear = 1'b0;
    endtask

    bit [31:0] q [$];
    int        m_addr;
    bit        m_err;
    bit [31:0] words [DEPTH+1];

    initial begin
        rst_n = 1'b0; clear = 1'b0; req_valid = 1'b0; inst_ready = 1'b0;
        type_s = '0; rd = '0; rs1 = '0; rs2 = '0; f3 = '0; imm = '0;

        vecs[0]  = mk(0, 1, 0, 0, 0, 5,     32'h0050_0093, 1'b0);
        vecs[1]  = mk(1, 2, 1, 0, 2, 8,     32'h0080_A103, 1'b0);
        vecs[2]  = mk(2, 0, 1, 2, 2, 12,    32'h0020_A623, 1'b0);
        vecs[3]  = mk(3, 0, 1, 2, 0, -8,    32'hFE20_8CE3, 1'b0);
        vecs[4]  = mk(0, 0, 0, 0, 0, 2047,  32'h7FF0_0013, 1'b0);
        vecs[5]  = mk(0, 0, 0, 0, 0, -2048, 32'h8000_0013, 1'b0);
        vecs[6]  = mk(3, 0, 0, 0, 0, 4094,  32'h7E00_0FE3, 1'b0);
        vecs[7]  = mk(3, 0, 0, 0, 0, -4096, 32'h8000_0063, 1'b0);
        vecs[8]  = mk(2, 0, 0, 0, 0, -1,    32'hFE00_0FA3, 1'b0);
        vecs[9]  = mk(0, 1, 0, 0, 0, 2048,  32'h0,         1'b1);
        vecs[10] = mk(3, 0, 1, 2, 0, 3,     32'h0,         1'b1);
        vecs[11] = mk(1, 1, 0, 0, 0, -2049, 32'h0,         1'b1);
        vecs[12] = mk(3, 0, 0, 0, 0, 4096,  32'h0,         1'b1);

        // Reset state
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        check("rst_ready", {31'b0, req_ready}, 32'h1);
        check("rst_valid", {31'b0, inst_valid}, 32'h0);
        check("rst_inst", inst, 32'h0);
        check("rst_addr", addr, 32'h0);
        check("rst_err", {31'b0, err}, 32'h0);
`ifdef ENC_ROUNDTRIP_CHK_EN
        check("rst_chk", {31'b0, chk_fail}, 32'h0);
`endif

        // Latency and first pop
        set_req(0, 1, 0, 0, 0, 5);
        step();
        req_valid = 1'b0;
        check("lat_valid", {31'b0, inst_valid}, 32'h1);
        check("lat_inst", inst, 32'h0050_0093);
        check("lat_addr", addr, 32'h0);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        check("pop_addr", addr, 32'h4);
        check("pop_empty", {31'b0, inst_valid}, 32'h0);

        // Table of single-request vectors
        for (int i = 0; i < 13; i++) begin
            do_clear();
            set_req(vecs[i].t, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].f3, vecs[i].imm);
            step();
            req_valid = 1'b0;
            check($sformatf("vec%0d_err", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
            check($sformatf("vec%0d_valid", i), {31'b0, inst_valid}, {31'b0, !vecs[i].exp_err});
            if (!vecs[i].exp_err)
                check($sformatf("vec%0d_word", i), inst, vecs[i].exp_word);
            inst_ready = 1'b1;
            step();
            inst_ready = 1'b0;
        end

        // Two bad requests back to back, then a good one still encodes
        do_clear();
        set_req(0, 1, 0, 0, 0, 2048);
        step();
        check("bad1_err", {31'b0, err}, 32'h1);
        set_req(3, 0, 1, 2, 0, 3);
        step();
        set_req(1, 2, 1, 0, 2, 8);
        step();
        req_valid = 1'b0;
        check("bad_then_good_err", {31'b0, err}, 32'h1);
        check("bad_then_good_word", inst, 32'h0080_A103);
        check("bad_then_good_addr", addr, 32'h0);

        // Fill to full with consumer stalled; one pop frees a slot a cycle later
        do_clear();
        for (int k = 0; k <= DEPTH; k++) words[k] = model_enc(0, k + 1, k, 0, 1, k * 3 - 7);
        for (int k = 0; k < DEPTH; k++) begin
            set_req(0, k + 1, k, 0, 1, k * 3 - 7);
            step();
        end
        set_req(0, DEPTH + 1, DEPTH, 0, 1, DEPTH * 3 - 7);
        #1;
        check("full_ready", {31'b0, req_ready}, 32'h0);
        check("full_hold_word", inst, words[0]);
        inst_ready = 1'b1;
        #1;
        check("full_pop_ready", {31'b0, req_ready}, 32'h0);
        step();
        inst_ready = 1'b0;
        #1;
        check("after_pop_ready", {31'b0, req_ready}, 32'h1);
        step();
        req_valid = 1'b0;
        inst_ready = 1'b1;
        for (int k = 1; k <= DEPTH; k++) begin
            check($sformatf("drain%0d_word", k), inst, words[k]);
            check($sformatf("drain%0d_addr", k), addr, 32'(4 * k));
            step();
        end
        inst_ready = 1'b0;
        check("drain_empty", {31'b0, inst_valid}, 32'h0);

        // Clear with words queued, error set and a request pending
        do_clear();
        for (int k = 0; k < 3; k++) begin
            set_req(2, 0, k, k + 1, 2, k * 4);
            step();
        end
        set_req(0, 1, 0, 0, 0, -5000);
        step();
        check("pre_clear_err", {31'b0, err}, 32'h1);
        set_req(0, 1, 0, 0, 0, 5);
        clear = 1'b1;
        #1;
        check("clear_ready", {31'b0, req_ready}, 32'h0);
        step();
        clear = 1'b0;
        req_valid = 1'b0;
        check("clear_valid", {31'b0, inst_valid}, 32'h0);
        check("clear_addr", addr, 32'h0);
        check("clear_err", {31'b0, err}, 32'h0);

        // Asynchronous reset mid-stream
        set_req(0, 3, 0, 0, 0, 1);
        step();
        step();
        inst_ready = 1'b1;
        step();
        req_valid = 1'b0;
        inst_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("arst_valid", {31'b0, inst_valid}, 32'h0);
        check("arst_addr", addr, 32'h0);
        check("arst_inst", inst, 32'h0);
        step();
        rst_n = 1'b1;

        // Randomized traffic against the queue model
        do_clear();
        q.delete();
        m_addr = 0;
        m_err  = 1'b0;
        for (int c = 0; c < 400; c++) begin
            int  t, im;
            bit  acc, pop, clr;
            bit [31:0] w;
            t  = $urandom_range(0, 3);
            im = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 12000)) - 6000
                                             : int'($urandom_range(0, 4000)) - 2000;
            if (t == 3 && $urandom_range(0, 3) != 0) im = im & ~1;
            clr = ($urandom_range(0, 39) == 0);
            set_req(t, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                    $urandom_range(0, 7), im);
            req_valid  = ($urandom_range(0, 2) != 0);
            inst_ready = ($urandom_range(0, 1) != 0);
            clear      = clr;
            #1;
            check("rnd_ready", {31'b0, req_ready}, {31'b0, (q.size() < DEPTH) && !clr});
            check("rnd_valid", {31'b0, inst_valid}, {31'b0, q.size() > 0});
            check("rnd_err", {31'b0, err}, {31'b0, m_err});
            if (q.size() > 0) begin
                check("rnd_word", inst, q[0]);
                check("rnd_addr", addr, 32'(m_addr));
            end
            acc = req_valid && (q.size() < DEPTH) && !clr;
            pop = inst_ready && (q.size() > 0);
            w   = model_enc(t, rd, rs1, rs2, f3, im);
            if (clr) begin
                q.delete();
                m_addr = 0;
                m_err  = 1'b0;
            end else begin
                if (pop) begin
                    void'(q.pop_front());
                    m_addr += 4;
                end
                if (acc) begin
                    if (model_ok(t, im)) q.push_back(w);
                    else m_err = 1'b1;
                end
            end
            step();
        end
        req_valid = 1'b0;
        inst_ready = 1'b0;
        clear = 1'b0;
`ifdef ENC_ROUNDTRIP_CHK_EN
        check("chk_fail_clean", {31'b0, chk_fail}, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
